// File: rtl/mux_scan_sel.sv
// Registered channel selector with manual select and auto-scan with per-channel dwell.
// out/out_ch follow next_ch one clock later; chg flags a new channel index.
module mux_scan_sel #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int DWELL = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 chg
);
    // state  | meaning
    // MANUAL | out_ch follows (clamped) sel, dwell counter parked at 0
    // SCAN   | out_ch steps 0..NCH-1 every DWELL cycles unless hold
    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [SELW-1:0]   sel_c, next_ch;
    logic [WIDTH-1:0]  ch_data;

    // Clamp only exists when the select field can encode unused channels.
    generate
        if ((1 << SELW) > NCH) begin : g_clamp
            assign sel_c = (sel > LAST_CH) ? LAST_CH : sel;
        end else begin : g_noclamp
            assign sel_c = sel;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = mode ? SCAN : MANUAL;
    end

    // Mode is decoded from the input so a mode change wins over a dwell expiry.
    always_comb begin
        next_ch = out_ch;
        cnt_nxt = cnt;
        if (!mode) begin
            next_ch = sel_c;
            cnt_nxt = '0;
        end else if (state == MANUAL) begin
            next_ch = out_ch;
            cnt_nxt = '0;
        end else if (!hold) begin
            if (cnt == LAST_CNT) begin
                cnt_nxt = '0;
                next_ch = (out_ch == LAST_CH) ? '0 : out_ch + 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (next_ch == SELW'(k)) begin
                ch_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            out_ch <= '0;
            cnt    <= '0;
            chg    <= 1'b0;
        end else begin
            out    <= ch_data;
            out_ch <= next_ch;
            cnt    <= cnt_nxt;
            chg    <= (next_ch != out_ch);
        end
    end
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: default build via vector table, plus NCH=3
// and DWELL=1 builds driven by short hand sequences.
module tb_mux_scan_sel;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default build
    logic        rst_a, mode_a, hold_a;
    logic [1:0]  sel_a;
    logic [31:0] bus_a;
    logic [7:0]  out_a;
    logic [1:0]  ch_a;
    logic        chg_a;

    mux_scan_sel #(.WIDTH(8), .NCH(4), .DWELL(4)) u_def (
        .clk(clk), .reset(rst_a), .in_bus(bus_a), .sel(sel_a), .mode(mode_a),
        .hold(hold_a), .out(out_a), .out_ch(ch_a), .chg(chg_a));

    // three-channel build
    logic        rst_b3, mode_b3, hold_b3;
    logic [1:0]  sel_b3;
    logic [23:0] bus_b3;
    logic [7:0]  out_b3;
    logic [1:0]  ch_b3;
    logic        chg_b3;

    mux_scan_sel #(.WIDTH(8), .NCH(3), .DWELL(4)) u_n3 (
        .clk(clk), .reset(rst_b3), .in_bus(bus_b3), .sel(sel_b3), .mode(mode_b3),
        .hold(hold_b3), .out(out_b3), .out_ch(ch_b3), .chg(chg_b3));

    // single-cycle dwell build
    logic        rst_c, mode_c, hold_c;
    logic [1:0]  sel_c;
    logic [31:0] bus_c;
    logic [7:0]  out_c;
    logic [1:0]  ch_c;
    logic        chg_c;

    mux_scan_sel #(.WIDTH(8), .NCH(4), .DWELL(1)) u_d1 (
        .clk(clk), .reset(rst_c), .in_bus(bus_c), .sel(sel_c), .mode(mode_c),
        .hold(hold_c), .out(out_c), .out_ch(ch_c), .chg(chg_c));

    typedef struct {
        logic        rst, mode, hold;
        logic [1:0]  sel;
        logic [31:0] bus;
        logic [7:0]  eout;
        logic [1:0]  ech;
        logic        echg;
    } vec_t;

    vec_t tv[$];

    localparam logic [31:0] BUS_D = 32'hDDCC_BBAA;
    localparam logic [31:0] BUS_H = 32'hDDCC_55AA;

    task automatic add(input logic r, input logic m, input logic h, input logic [1:0] s,
                       input logic [31:0] b, input logic [7:0] eo, input logic [1:0] ec,
                       input logic eg);
        vec_t v;
        v.rst = r; v.mode = m; v.hold = h; v.sel = s; v.bus = b;
        v.eout = eo; v.ech = ec; v.echg = eg;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step3(input logic r, input logic m, input logic [1:0] s,
                         input logic [7:0] eo, input logic [1:0] ec, input logic eg,
                         input string tag);
        rst_b3 = r; mode_b3 = m; sel_b3 = s;
        @(posedge clk); #1;
        check({tag, ".out"}, {24'h0, out_b3}, {24'h0, eo});
        check({tag, ".ch"},  {30'h0, ch_b3},  {30'h0, ec});
        check({tag, ".chg"}, {31'h0, chg_b3}, {31'h0, eg});
    endtask

    task automatic step1(input logic r, input logic m, input logic h,
                         input logic [7:0] eo, input logic [1:0] ec, input logic eg,
                         input string tag);
        rst_c = r; mode_c = m; hold_c = h;
        @(posedge clk); #1;
        check({tag, ".out"}, {24'h0, out_c}, {24'h0, eo});
        check({tag, ".ch"},  {30'h0, ch_c},  {30'h0, ec});
        check({tag, ".chg"}, {31'h0, chg_c}, {31'h0, eg});
    endtask

    initial begin
        rst_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; sel_a = 2'd0; bus_a = BUS_D;
        rst_b3 = 1'b1; mode_b3 = 1'b0; hold_b3 = 1'b0; sel_b3 = 2'd0; bus_b3 = 24'hCCBBAA;
        rst_c = 1'b1; mode_c = 1'b0; hold_c = 1'b0; sel_c = 2'd0; bus_c = BUS_D;

        //  rst mode hold sel bus     out    ch  chg
        add(1, 0, 0, 0, BUS_D, 8'h00, 0, 0);   // reset
        add(1, 1, 1, 3, BUS_D, 8'h00, 0, 0);   // reset dominates
        add(0, 0, 0, 2, BUS_D, 8'hCC, 2, 1);   // manual select
        add(0, 0, 0, 2, BUS_D, 8'hCC, 2, 0);   // same index, no chg
        add(0, 1, 0, 2, BUS_D, 8'hCC, 2, 0);   // scan entry, cnt 0
        add(0, 1, 0, 2, BUS_D, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_D, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_D, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_D, 8'hDD, 3, 1);   // dwell expiry
        add(0, 1, 0, 2, BUS_D, 8'hDD, 3, 0);
        add(0, 1, 0, 2, BUS_D, 8'hDD, 3, 0);
        add(0, 1, 0, 2, BUS_D, 8'hDD, 3, 0);
        add(0, 1, 0, 2, BUS_D, 8'hAA, 0, 1);   // wrap
        add(0, 1, 0, 2, BUS_D, 8'hAA, 0, 0);
        add(0, 1, 0, 2, BUS_D, 8'hAA, 0, 0);
        add(0, 1, 0, 2, BUS_D, 8'hAA, 0, 0);
        add(0, 1, 0, 2, BUS_D, 8'hBB, 1, 1);   // ch1 cnt 0
        add(0, 1, 0, 2, BUS_D, 8'hBB, 1, 0);   // ch1 cnt 1
        add(0, 1, 1, 2, BUS_D, 8'hBB, 1, 0);   // hold
        add(0, 1, 1, 2, BUS_H, 8'h55, 1, 0);   // data refresh under hold
        add(0, 1, 1, 2, BUS_H, 8'h55, 1, 0);
        add(0, 1, 0, 2, BUS_H, 8'h55, 1, 0);   // release, cnt 2
        add(0, 1, 0, 2, BUS_H, 8'h55, 1, 0);   // cnt 3
        add(0, 1, 0, 2, BUS_H, 8'hCC, 2, 1);   // advance
        add(0, 1, 0, 2, BUS_H, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_H, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_D, 8'hCC, 2, 0);
        add(0, 1, 0, 2, BUS_D, 8'hDD, 3, 1);
        add(0, 0, 1, 1, BUS_D, 8'hBB, 1, 1);   // mode drop loads sel
        add(0, 0, 1, 1, BUS_D, 8'hBB, 1, 0);   // hold ignored in manual
        add(0, 1, 0, 1, BUS_D, 8'hBB, 1, 0);   // scan entry
        add(0, 1, 0, 1, BUS_D, 8'hBB, 1, 0);
        add(0, 1, 0, 1, BUS_D, 8'hBB, 1, 0);
        add(0, 1, 0, 1, BUS_D, 8'hBB, 1, 0);   // cnt now 3
        add(0, 0, 0, 3, BUS_D, 8'hDD, 3, 1);   // mode drop beats expiry
        add(1, 1, 0, 3, BUS_D, 8'h00, 0, 0);   // reset
        add(0, 0, 0, 0, BUS_D, 8'hAA, 0, 0);   // index 0 after reset, no chg

        @(posedge clk); #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst_a = tv[i].rst; mode_a = tv[i].mode; hold_a = tv[i].hold;
            sel_a = tv[i].sel; bus_a = tv[i].bus;
            @(posedge clk); #1;
            check($sformatf("v%0d.out", i), {24'h0, out_a}, {24'h0, tv[i].eout});
            check($sformatf("v%0d.ch", i),  {30'h0, ch_a},  {30'h0, tv[i].ech});
            check($sformatf("v%0d.chg", i), {31'h0, chg_a}, {31'h0, tv[i].echg});
        end

        // NCH=3: clamp, non-power-of-2 wrap, reset mid-scan
        step3(1, 0, 0, 8'h00, 0, 0, "n3_rst");
        step3(0, 0, 3, 8'hCC, 2, 1, "n3_clamp");
        step3(0, 1, 3, 8'hCC, 2, 0, "n3_entry");
        step3(0, 1, 3, 8'hCC, 2, 0, "n3_c1");
        step3(0, 1, 3, 8'hCC, 2, 0, "n3_c2");
        step3(0, 1, 3, 8'hCC, 2, 0, "n3_c3");
        step3(0, 1, 3, 8'hAA, 0, 1, "n3_wrap");
        step3(0, 1, 3, 8'hAA, 0, 0, "n3_c1b");
        step3(1, 1, 3, 8'h00, 0, 0, "n3_midrst");
        step3(0, 0, 1, 8'hBB, 1, 1, "n3_resume");

        // DWELL=1: advance every cycle with chg held high
        step1(1, 0, 0, 8'h00, 0, 0, "d1_rst");
        step1(0, 1, 0, 8'hAA, 0, 0, "d1_entry");
        step1(0, 1, 0, 8'hBB, 1, 1, "d1_s1");
        step1(0, 1, 0, 8'hCC, 2, 1, "d1_s2");
        step1(0, 1, 0, 8'hDD, 3, 1, "d1_s3");
        step1(0, 1, 0, 8'hAA, 0, 1, "d1_wrap");
        step1(0, 1, 1, 8'hAA, 0, 0, "d1_hold");
        step1(0, 1, 0, 8'hBB, 1, 1, "d1_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
